// File: rtl/lb_pkg.sv
// lb_pkg: shared localbus constants and the lb_master FSM state type.
//   LBCWIDTH/LBAWIDTH/LBDWIDTH : default ctrl/addr/data field widths
//   WRITECMD/READCMD           : default ctrl codes placed in the command word
//   lbm_state_t                : initiator FSM states
package lb_pkg;
  localparam int LBCWIDTH = 8;
  localparam int LBAWIDTH = 24;
  localparam int LBDWIDTH = 32;
  localparam int WRITECMD = 1;
  localparam int READCMD  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lbm_state_t;
endpackage

// File: rtl/lb_master_if.sv
// lb_master_if: request, localbus and response signals of the localbus initiator.
//   request  : req_valid/req_ready/req_write/req_addr/req_wdata
//   localbus : lb_wcmd/lb_wvalid (command out), lb_rcmd/lb_rready (echo in)
//   response : rsp_valid/rsp_ready/rsp_write/rsp_addr/rsp_rdata/rsp_err
// modport master is the initiator's view, slave is host + responder.
interface lb_master_if #(
  parameter int LBCWIDTH = lb_pkg::LBCWIDTH,
  parameter int LBAWIDTH = lb_pkg::LBAWIDTH,
  parameter int LBDWIDTH = lb_pkg::LBDWIDTH
);
  localparam int LBW = LBCWIDTH + LBAWIDTH + LBDWIDTH;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [LBAWIDTH-1:0] req_addr;
  logic [LBDWIDTH-1:0] req_wdata;

  logic [LBW-1:0]      lb_wcmd;
  logic                lb_wvalid;
  logic [LBW-1:0]      lb_rcmd;
  logic                lb_rready;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_write;
  logic [LBAWIDTH-1:0] rsp_addr;
  logic [LBDWIDTH-1:0] rsp_rdata;
  logic                rsp_err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, lb_rcmd, lb_rready, rsp_ready,
    output req_ready, lb_wcmd, lb_wvalid, rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, lb_rcmd, lb_rready, rsp_ready,
    input  req_ready, lb_wcmd, lb_wvalid, rsp_valid, rsp_write, rsp_addr, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lb_master.sv
// lb_master: single-outstanding localbus initiator.
// Takes one request, issues a one-cycle {ctrl,addr,data} command, waits for the
// responder echo (or a timeout) and presents the result on the response port.
//   clk, rstn     : clock, asynchronous active-low reset
//   bus (master)  : request / localbus / response signals (see lb_master_if)
//   stat_timeouts : saturating count of timed-out transactions
module lb_master #(
  parameter int LBCWIDTH = lb_pkg::LBCWIDTH,
  parameter int LBAWIDTH = lb_pkg::LBAWIDTH,
  parameter int LBDWIDTH = lb_pkg::LBDWIDTH,
  parameter int WRITECMD = lb_pkg::WRITECMD,
  parameter int READCMD  = lb_pkg::READCMD,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rstn,
  lb_master_if.master bus,
  output logic [15:0] stat_timeouts
);
  localparam int LBW = LBCWIDTH + LBAWIDTH + LBDWIDTH;
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  lb_pkg::lbm_state_t state, state_nx;
  logic [CW-1:0]       tmo_cnt;
  logic                accept, echo_hit, tmo_hit, echo_bad;
  logic [LBCWIDTH-1:0] req_ctrl;

  assign bus.req_ready = (state == lb_pkg::IDLE);
  assign accept        = bus.req_ready && bus.req_valid;
  assign req_ctrl      = bus.req_write ? LBCWIDTH'(WRITECMD) : LBCWIDTH'(READCMD);

  // lb_wcmd holds the issued command for the whole transaction, so the echo
  // is checked against it directly instead of a separate copy.
  assign echo_bad = (bus.lb_rcmd[LBW-1 -: LBCWIDTH] != bus.lb_wcmd[LBW-1 -: LBCWIDTH]) ||
                    (bus.lb_rcmd[LBDWIDTH +: LBAWIDTH] != bus.lb_wcmd[LBDWIDTH +: LBAWIDTH]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= lb_pkg::IDLE;
    else       state <= state_nx;
  end

  // Echo beats timeout when both land in the same cycle.
  always_comb begin
    state_nx = state;
    echo_hit = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      lb_pkg::IDLE:  if (bus.req_valid) state_nx = lb_pkg::ISSUE;
      lb_pkg::ISSUE: begin
        echo_hit = bus.lb_rready;
        state_nx = bus.lb_rready ? lb_pkg::RESP : lb_pkg::WAIT;
      end
      lb_pkg::WAIT: begin
        if (bus.lb_rready) begin
          echo_hit = 1'b1;
          state_nx = lb_pkg::RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = lb_pkg::RESP;
        end
      end
      lb_pkg::RESP:  if (bus.rsp_ready) state_nx = lb_pkg::IDLE;
      default:       state_nx = lb_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.lb_wvalid <= 1'b0;
      bus.lb_wcmd   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      stat_timeouts <= '0;
      tmo_cnt       <= '0;
    end else begin
      bus.lb_wvalid <= accept;
      if (accept) begin
        bus.lb_wcmd   <= {req_ctrl, bus.req_addr, bus.req_write ? bus.req_wdata : '0};
        bus.rsp_write <= bus.req_write;
        bus.rsp_addr  <= bus.req_addr;
      end
      if (state == lb_pkg::ISSUE)     tmo_cnt <= '0;
      else if (state == lb_pkg::WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (echo_hit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= echo_bad;
        bus.rsp_rdata <= bus.lb_rcmd[LBDWIDTH-1:0];
      end else if (tmo_hit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
        if (stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
      end else if (state == lb_pkg::RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule
